// File: rtl/sram_ctrl_if.sv
// Bus bundle between the MEM stage, the SRAM controller and the external asynchronous SRAM.
// Also provides the shared memory-op encodings (MEM_*) when no common header has defined them.
`ifndef MEM_NOP
`define MEM_NOP 4'd0
`define MEM_LB  4'd1
`define MEM_LBU 4'd2
`define MEM_LH  4'd3
`define MEM_LHU 4'd4
`define MEM_LW  4'd5
`define MEM_SB  4'd6
`define MEM_SH  4'd7
`define MEM_SW  4'd8
`endif

interface sram_ctrl_if;
  logic [3:0]  ramOp_i;
  logic [31:0] ramAddr_i;
  logic [31:0] storeData_i;
  logic [31:0] load_data_o;
  logic        stall_req_o;
  logic [19:0] sram_addr_o;
  logic [31:0] sram_wdata_o;
  logic [31:0] sram_rdata_i;
  logic        sram_ce_n_o;
  logic        sram_oe_n_o;
  logic        sram_we_n_o;
  logic [3:0]  sram_be_n_o;

  modport master (
    output ramOp_i, ramAddr_i, storeData_i, sram_rdata_i,
    input  load_data_o, stall_req_o, sram_addr_o, sram_wdata_o,
    input  sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o
  );

  modport slave (
    input  ramOp_i, ramAddr_i, storeData_i, sram_rdata_i,
    output load_data_o, stall_req_o, sram_addr_o, sram_wdata_o,
    output sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o
  );
endinterface

// File: rtl/sram_ctrl.sv
// Multi-cycle asynchronous SRAM controller for the MEM stage: IDLE -> ACCESS -> DONE.
// Define MEM_CTRL_STORE_BUF_EN for posted stores (no stall, ACCESS returns straight to IDLE).
module sram_ctrl #(
  parameter int WAIT_CYCLES = 2
) (
  input logic       clk,
  input logic       rst,
  sram_ctrl_if.slave bus
);

`ifdef MEM_CTRL_STORE_BUF_EN
  localparam logic POSTED = 1'b1;
`else
  localparam logic POSTED = 1'b0;
`endif

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [3:0]  op_q;
  logic [1:0]  lane_q;
  logic        accept;
  logic        stall;
  logic [31:0] load_data;
  logic [19:0] sram_addr;
  logic [31:0] sram_wdata;
  logic        ce_n, oe_n, we_n;
  logic [3:0]  be_n;
  logic        unused_addr_bits;

  function automatic logic is_load(input logic [3:0] op);
    return (op == `MEM_LB) || (op == `MEM_LBU) || (op == `MEM_LH) ||
           (op == `MEM_LHU) || (op == `MEM_LW);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == `MEM_SB) || (op == `MEM_SH) || (op == `MEM_SW);
  endfunction

  function automatic logic [3:0] lane_be_n(input logic [3:0] op, input logic [1:0] lane);
    case (op)
      `MEM_SB: return ~(4'b0001 << lane);
      `MEM_SH: return lane[1] ? 4'b0011 : 4'b1100;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [3:0] op, input logic [31:0] data);
    case (op)
      `MEM_SB: return {4{data[7:0]}};
      `MEM_SH: return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [3:0] op, input logic [1:0] lane,
                                               input logic [31:0] word);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (op)
      `MEM_LB:  r = 32'(b);
      `MEM_LBU: r = {24'h000000, b};
      `MEM_LH:  r = 32'(h);
      `MEM_LHU: r = {16'h0000, h};
      default:  r = word;
    endcase
    return r;
  endfunction

  // Only the word address and lane bits reach the SRAM; the rest is decoded upstream.
  assign unused_addr_bits = ^bus.ramAddr_i[31:22];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.ramOp_i != `MEM_NOP) begin
          accept    = 1'b1;
          cnt_nxt   = 4'd0;
          state_nxt = ACCESS;
          stall     = !(POSTED && is_store(bus.ramOp_i));
        end
      end
      ACCESS: begin
        // A posted store only holds the pipeline if a new op is waiting behind it.
        stall = POSTED ? (is_load(op_q) || (bus.ramOp_i != `MEM_NOP)) : 1'b1;
        if (cnt == LAST) begin
          cnt_nxt   = 4'd0;
          state_nxt = (POSTED && is_store(op_q)) ? IDLE : DONE;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      op_q       <= `MEM_NOP;
      lane_q     <= 2'd0;
      load_data  <= 32'h0;
      sram_addr  <= 20'h0;
      sram_wdata <= 32'h0;
      ce_n       <= 1'b1;
      oe_n       <= 1'b1;
      we_n       <= 1'b1;
      be_n       <= 4'b1111;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      // Strobes are registered so they change only on clock edges and stay glitch-free.
      if (accept) begin
        op_q       <= bus.ramOp_i;
        lane_q     <= bus.ramAddr_i[1:0];
        sram_addr  <= bus.ramAddr_i[21:2];
        sram_wdata <= store_wdata(bus.ramOp_i, bus.storeData_i);
        ce_n       <= 1'b0;
        oe_n       <= !is_load(bus.ramOp_i);
        we_n       <= !is_store(bus.ramOp_i);
        be_n       <= lane_be_n(bus.ramOp_i, bus.ramAddr_i[1:0]);
      end else if (state_nxt != ACCESS) begin
        ce_n <= 1'b1;
        oe_n <= 1'b1;
        we_n <= 1'b1;
        be_n <= 4'b1111;
      end else if (cnt_nxt == LAST) begin
        we_n <= 1'b1;
      end
      if ((state == ACCESS) && (cnt == LAST) && is_load(op_q))
        load_data <= load_extract(op_q, lane_q, bus.sram_rdata_i);
    end
  end

  assign bus.stall_req_o  = stall;
  assign bus.load_data_o  = load_data;
  assign bus.sram_addr_o  = sram_addr;
  assign bus.sram_wdata_o = sram_wdata;
  assign bus.sram_ce_n_o  = ce_n;
  assign bus.sram_oe_n_o  = oe_n;
  assign bus.sram_we_n_o  = we_n;
  assign bus.sram_be_n_o  = be_n;

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: transaction-level reference model, per-cycle compare,
// a behavioural SRAM, and directed literal cases; follows MEM_CTRL_STORE_BUF_EN if defined.
`ifndef MEM_NOP
`define MEM_NOP 4'd0
`define MEM_LB  4'd1
`define MEM_LBU 4'd2
`define MEM_LH  4'd3
`define MEM_LHU 4'd4
`define MEM_LW  4'd5
`define MEM_SB  4'd6
`define MEM_SH  4'd7
`define MEM_SW  4'd8
`endif

module tb_sram_ctrl;
  localparam int W = 2;
`ifdef MEM_CTRL_STORE_BUF_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  sram_ctrl_if bus ();

  sram_ctrl #(.WAIT_CYCLES(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural SRAM plus a preload port owned by the same process.
  logic [31:0] mem [0:15];
  logic        pl_en;
  logic [3:0]  pl_idx;
  logic [31:0] pl_val;
  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (!bus.sram_ce_n_o && !bus.sram_we_n_o)
      for (int i = 0; i < 4; i++)
        if (!bus.sram_be_n_o[i]) mem[bus.sram_addr_o[3:0]][8*i +: 8] <= bus.sram_wdata_o[8*i +: 8];
  end
  assign bus.sram_rdata_i = (!bus.sram_ce_n_o && !bus.sram_oe_n_o) ? mem[bus.sram_addr_o[3:0]] : 32'h0;

  // Reference model state.
  logic [31:0] ref_mem [0:15];
  bit          chk_en, tx_on, tx_load, tx_store;
  int          tx_start;
  logic [19:0] tx_addr;
  logic [3:0]  tx_be;
  logic [31:0] tx_wdata, tx_ld, prev_ld;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic bit is_ld(input logic [3:0] op);
    return op inside {`MEM_LB, `MEM_LBU, `MEM_LH, `MEM_LHU, `MEM_LW};
  endfunction
  function automatic bit is_st(input logic [3:0] op);
    return op inside {`MEM_SB, `MEM_SH, `MEM_SW};
  endfunction

  function automatic int byte_of(input logic [31:0] w, input int i);
    return int'((w >> (8 * i)) & 32'hFF);
  endfunction

  function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] word, input int lane);
    int v;
    case (op)
      `MEM_LB:  begin v = byte_of(word, lane); if (v >= 128) v -= 256; end
      `MEM_LBU: v = byte_of(word, lane);
      `MEM_LH:  begin v = byte_of(word, lane) + 256 * byte_of(word, lane + 1); if (v >= 32768) v -= 65536; end
      `MEM_LHU: v = byte_of(word, lane) + 256 * byte_of(word, lane + 1);
      default:  v = int'(word);
    endcase
    return 32'(v);
  endfunction

  // Which data byte a store puts into lane i, or -1 when lane i is untouched.
  function automatic int src_byte(input logic [3:0] op, input int lane, input int i);
    case (op)
      `MEM_SB: return (i == lane) ? 0 : -1;
      `MEM_SH: return (i / 2 == lane / 2) ? i % 2 : -1;
      `MEM_SW: return i;
      default: return -1;
    endcase
  endfunction

  // Per-cycle comparison against the transaction timeline: k=0 accept, 1..W access, W+1 done.
  always @(negedge clk) begin
    int k;
    bit acc;
    if (chk_en) begin
      k   = cyc - tx_start;
      acc = tx_on && k >= 1 && k <= W;
      chk("stall", {31'b0, bus.stall_req_o}, {31'b0, tx_on && k <= W && !(POSTED && tx_store)});
      chk("ce_n", {31'b0, bus.sram_ce_n_o}, {31'b0, !acc});
      chk("oe_n", {31'b0, bus.sram_oe_n_o}, {31'b0, !(acc && tx_load)});
      chk("we_n", {31'b0, bus.sram_we_n_o}, {31'b0, !(acc && tx_store && k < W)});
      chk("be_n", {28'b0, bus.sram_be_n_o}, {28'b0, acc ? tx_be : 4'b1111});
      if (acc) chk("addr", {12'b0, bus.sram_addr_o}, {12'b0, tx_addr});
      if (acc && tx_store) chk("wdata", bus.sram_wdata_o, tx_wdata);
      chk("load_data", bus.load_data_o, (tx_on && tx_load && k >= W + 1) ? tx_ld : prev_ld);
    end
  end

  task automatic preload(input int idx, input logic [31:0] val);
    ref_mem[idx] = val;
    @(posedge clk); #1;
    pl_idx = 4'(idx); pl_val = val; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                       output int stalls, output int wes, output logic [19:0] a_seen,
                       output logic [3:0] be_seen, output logic [31:0] wd_seen,
                       output logic [31:0] ld_done, output logic ce_done);
    int hold, span, lane, widx;
    logic [31:0] nw;
    hold = (POSTED && is_st(op)) ? 1 : W + 2;
    span = (POSTED && is_st(op)) ? W + 1 : W + 2;
    lane = int'(addr[1:0]);
    widx = int'(addr[5:2]);
    stalls = 0; wes = 0; a_seen = '0; be_seen = '0; wd_seen = '0; ld_done = '0; ce_done = 1'b0;
    for (int k = 0; k < span; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        bus.ramOp_i = op; bus.ramAddr_i = addr; bus.storeData_i = data;
        if (tx_on && tx_load) prev_ld = tx_ld;
        tx_load  = is_ld(op);
        tx_store = is_st(op);
        tx_addr  = 20'((addr >> 2) & 32'hFFFFF);
        tx_be    = tx_load ? 4'b0000 : 4'b1111;
        tx_wdata = '0;
        nw       = ref_mem[widx];
        for (int i = 0; i < 4; i++) begin
          int s;
          s = src_byte(op, lane, i);
          if (s >= 0) begin
            tx_be[i] = 1'b0;
            tx_wdata[8*i +: 8] = 8'(byte_of(data, s));
            nw[8*i +: 8] = 8'(byte_of(data, s));
          end else if (op == `MEM_SB) tx_wdata[8*i +: 8] = data[7:0];
          else if (op == `MEM_SH) tx_wdata[8*i +: 8] = 8'(byte_of(data, i % 2));
        end
        tx_ld = ref_load(op, ref_mem[widx], lane);
        if (tx_store) ref_mem[widx] = nw;
        tx_start = cyc;
        tx_on = 1'b1;
      end else if (k == hold) begin
        bus.ramOp_i = `MEM_NOP;
      end
      #2;
      if (bus.stall_req_o) stalls++;
      if (!bus.sram_we_n_o) wes++;
      if (k == 1) begin a_seen = bus.sram_addr_o; be_seen = bus.sram_be_n_o; wd_seen = bus.sram_wdata_o; end
      if (k == W + 1) begin ld_done = bus.load_data_o; ce_done = bus.sram_ce_n_o; end
    end
    @(posedge clk); #1;
    bus.ramOp_i = `MEM_NOP;
  endtask

  initial begin
    int st, we;
    logic [19:0] a;
    logic [3:0]  be;
    logic [31:0] wd, ld;
    logic        ce;
    int n;
    rst = 1'b1;
    bus.ramOp_i = `MEM_NOP; bus.ramAddr_i = '0; bus.storeData_i = '0;
    pl_en = 1'b0; pl_idx = '0; pl_val = '0;
    chk_en = 1'b0; tx_on = 1'b0; tx_load = 1'b0; tx_store = 1'b0; tx_start = 0;
    tx_addr = '0; tx_be = '0; tx_wdata = '0; tx_ld = '0; prev_ld = '0;

    repeat (2) @(posedge clk);
    #3;
    chk("rst_stall", {31'b0, bus.stall_req_o}, 32'd0);
    chk("rst_load_data", bus.load_data_o, 32'h0);
    chk("rst_strobes", {29'b0, bus.sram_ce_n_o, bus.sram_oe_n_o, bus.sram_we_n_o}, 32'd7);
    chk("rst_be_n", {28'b0, bus.sram_be_n_o}, 32'hF);
    chk("rst_addr", {12'b0, bus.sram_addr_o}, 32'h0);
    chk("rst_wdata", bus.sram_wdata_o, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 16; i++) preload(i, $urandom);
    preload(0, 32'h80FF0011);
    preload(4, 32'h11223344);
    chk_en = 1'b1;

    do_op(`MEM_LW, 32'h80000010, 32'h0, st, we, a, be, wd, ld, ce);
    chk("lw_stall_cycles", st, 32'd3);
    chk("lw_sram_addr", {12'b0, a}, 32'h00004);
    chk("lw_data", ld, 32'h11223344);
    chk("lw_done_ce_n", {31'b0, ce}, 32'd1);

    do_op(`MEM_LB, 32'h80000003, 32'h0, st, we, a, be, wd, ld, ce);
    chk("lb_data", ld, 32'hFFFFFF80);
    do_op(`MEM_LBU, 32'h80000003, 32'h0, st, we, a, be, wd, ld, ce);
    chk("lbu_data", ld, 32'h00000080);
    do_op(`MEM_LH, 32'h80000002, 32'h0, st, we, a, be, wd, ld, ce);
    chk("lh_data", ld, 32'hFFFF80FF);

    do_op(`MEM_SB, 32'h80000001, 32'h000000AB, st, we, a, be, wd, ld, ce);
    chk("sb_be_n", {28'b0, be}, 32'hD);
    chk("sb_wdata", wd, 32'hABABABAB);
    chk("sb_we_cycles", we, 32'd1);
    chk("sb_stall_cycles", st, POSTED ? 32'd0 : 32'd3);
    do_op(`MEM_LW, 32'h80000000, 32'h0, st, we, a, be, wd, ld, ce);
    chk("sb_readback", ld, 32'h80FFAB11);

    for (int t = 0; t < 60; t++) begin
      logic [3:0] op;
      int lane;
      op = 4'($urandom_range(1, 8));
      if (op inside {`MEM_LB, `MEM_LBU, `MEM_SB}) lane = $urandom_range(0, 3);
      else if (op inside {`MEM_LH, `MEM_LHU, `MEM_SH}) lane = 2 * $urandom_range(0, 1);
      else lane = 0;
      do_op(op, 32'h80000000 | (32'($urandom_range(0, 15)) << 2) | 32'(lane), $urandom,
            st, we, a, be, wd, ld, ce);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // Reset in the first ACCESS cycle of a store.
    chk_en = 1'b0;
    @(posedge clk); #1;
    bus.ramOp_i = `MEM_SW; bus.ramAddr_i = 32'h80000024; bus.storeData_i = 32'h5A5A5A5A;
    @(posedge clk); #1;
    rst = 1'b1; bus.ramOp_i = `MEM_NOP;
    #2;
    chk("abort_started", {31'b0, bus.sram_we_n_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #2;
    chk("abort_stall", {31'b0, bus.stall_req_o}, 32'd0);
    chk("abort_strobes", {28'b0, bus.sram_ce_n_o, bus.sram_oe_n_o, bus.sram_we_n_o, 1'b0}, 32'hE);
    chk("abort_be_n", {28'b0, bus.sram_be_n_o}, 32'hF);
    chk("abort_load_data", bus.load_data_o, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #3;
      chk("abort_no_we", {30'b0, bus.sram_ce_n_o, bus.sram_we_n_o}, 32'd3);
    end
    preload(9, ref_mem[9]);
    tx_on = 1'b0; prev_ld = 32'h0;

`ifdef MEM_CTRL_STORE_BUF_EN
    // Posted SW followed immediately by LW to the same word.
    @(posedge clk); #1;
    bus.ramOp_i = `MEM_SW; bus.ramAddr_i = 32'h80000020; bus.storeData_i = 32'hCAFEF00D;
    #2;
    chk("posted_sw_stall", {31'b0, bus.stall_req_o}, 32'd0);
    @(posedge clk); #1;
    bus.ramOp_i = `MEM_LW; bus.ramAddr_i = 32'h80000020; bus.storeData_i = 32'h0;
    #2;
    n = 0;
    for (int i = 0; i < 20 && bus.stall_req_o; i++) begin
      n++;
      @(posedge clk); #3;
    end
    chk("posted_lw_stall_cycles", n, 32'd5);
    chk("posted_lw_data", bus.load_data_o, 32'hCAFEF00D);
    @(posedge clk); #1;
    bus.ramOp_i = `MEM_NOP;
    ref_mem[8] = 32'hCAFEF00D;
    prev_ld = 32'hCAFEF00D;
`endif

    chk_en = 1'b1;
    do_op(`MEM_LHU, 32'h80000002, 32'h0, st, we, a, be, wd, ld, ce);
    chk("lhu_data", ld, 32'h000080FF);
    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
